// File: rtl/mod_n_updown_counter.sv
// Parametrised synchronous modulo-N up/down counter with load, clear and a sticky wrap flag.
// Stages cascade by wiring tc of one instance to en of the next on the same clock.
module mod_n_updown_counter #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32,
    parameter int INIT    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] C_MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_INIT    = WIDTH'(INIT);
    // One extra bit so MODULUS == 2**WIDTH is representable in the load range check.
    localparam logic [WIDTH:0]   C_MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap_step;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;

    assign w_at_max    = (r_count == C_MAX);
    assign w_at_zero   = (r_count == '0);
    assign w_wrap_step = up_dn ? w_at_max : w_at_zero;

    // Out-of-range load values saturate at the top of the range.
    assign w_load_ok  = ({1'b0, load_val} < C_MOD_EXT);
    assign w_load_val = w_load_ok ? load_val : C_MAX;

    always_comb begin
        w_step_val = r_count;
        if (up_dn) begin
            w_step_val = w_at_max ? '0 : (r_count + WIDTH'(1));
        end else begin
            w_step_val = w_at_zero ? C_MAX : (r_count - WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= C_INIT;
            r_wrapped <= 1'b0;
        end else if (clear) begin
            r_count   <= C_INIT;
            r_wrapped <= 1'b0;
        end else if (load) begin
            r_count   <= w_load_val;
            r_wrapped <= 1'b0;
        end else if (en) begin
            r_count <= w_step_val;
            if (w_wrap_step) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    // Combinational so the next stage steps on the very edge that wraps this one.
    assign tc      = en & ~clear & ~load & w_wrap_step;
    assign count   = r_count;
    assign wrapped = r_wrapped;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Randomised and directed bench for mod_n_updown_counter: mod-10, mod-6 (INIT=2), mod-32
// standalone instances plus a mod-10 -> mod-6 cascade, all against an arithmetic reference model.
module tb_mod_n_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared controls for the standalone instances
    logic       reset, en, up_dn, clear, load;
    logic [4:0] lv;

    logic [3:0] c10; logic tc10, wr10;
    logic [2:0] c6;  logic tc6,  wr6;
    logic [4:0] c32; logic tc32, wr32;

    // Cascade: units tc drives tens en
    logic       c_rst, c_en;
    logic [3:0] cu;  logic tcu, wru;
    logic [2:0] ct;  logic tct, wrt;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_m10 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(lv[3:0]), .count(c10), .tc(tc10), .wrapped(wr10));

    mod_n_updown_counter #(.WIDTH(3), .MODULUS(6), .INIT(2)) u_m6 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(lv[2:0]), .count(c6), .tc(tc6), .wrapped(wr6));

    mod_n_updown_counter #(.WIDTH(5), .MODULUS(32), .INIT(0)) u_m32 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(lv), .count(c32), .tc(tc32), .wrapped(wr32));

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_units (
        .clk(clk), .reset(c_rst), .en(c_en), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
        .load_val(4'd0), .count(cu), .tc(tcu), .wrapped(wru));

    mod_n_updown_counter #(.WIDTH(3), .MODULUS(6), .INIT(0)) u_tens (
        .clk(clk), .reset(c_rst), .en(tcu), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
        .load_val(3'd0), .count(ct), .tc(tct), .wrapped(wrt));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model state
    int m10, m6, m32, mu, mt;
    bit w10, w6, w32, wu, wt;

    // One clock of a modulo-m counter described by its rules, using signed arithmetic.
    function automatic void model_step(input int m, input int init, input bit rst, input bit clr,
                                       input bit ld, input int ldv, input bit e, input bit up,
                                       inout int cnt, inout bit wr);
        int raw;
        if (rst || clr) begin
            cnt = init; wr = 1'b0;
        end else if (ld) begin
            cnt = (ldv < m) ? ldv : m - 1; wr = 1'b0;
        end else if (e) begin
            raw = cnt + (up ? 1 : -1);
            if (raw < 0 || raw >= m) wr = 1'b1;
            cnt = (raw + m) % m;
        end
    endfunction

    // Terminal count: this cycle is enabled and its step leaves the 0..m-1 range.
    function automatic bit model_tc(input int m, input int cnt, input bit clr, input bit ld,
                                    input bit e, input bit up);
        int raw;
        raw = cnt + (up ? 1 : -1);
        return e && !clr && !ld && (raw < 0 || raw >= m);
    endfunction

    task automatic tick();
        bit etu;
        @(negedge clk);
        check("tc10", int'(tc10), int'(model_tc(10, m10, clear, load, en, up_dn)));
        check("tc6",  int'(tc6),  int'(model_tc(6,  m6,  clear, load, en, up_dn)));
        check("tc32", int'(tc32), int'(model_tc(32, m32, clear, load, en, up_dn)));
        etu = model_tc(10, mu, 1'b0, 1'b0, c_en, 1'b1);
        check("tc_units", int'(tcu), int'(etu));
        check("tc_tens",  int'(tct), int'(model_tc(6, mt, 1'b0, 1'b0, etu, 1'b1)));
        @(posedge clk);
        #1;
        model_step(10, 0, reset, clear, load, int'(lv[3:0]), en, up_dn, m10, w10);
        model_step(6,  2, reset, clear, load, int'(lv[2:0]), en, up_dn, m6,  w6);
        model_step(32, 0, reset, clear, load, int'(lv),      en, up_dn, m32, w32);
        model_step(10, 0, c_rst, 1'b0, 1'b0, 0, c_en, 1'b1, mu, wu);
        model_step(6,  0, c_rst, 1'b0, 1'b0, 0, etu,  1'b1, mt, wt);
        check("count10", int'(c10), m10);  check("wrapped10", int'(wr10), int'(w10));
        check("count6",  int'(c6),  m6);   check("wrapped6",  int'(wr6),  int'(w6));
        check("count32", int'(c32), m32);  check("wrapped32", int'(wr32), int'(w32));
        check("units", int'(cu), mu);      check("tens", int'(ct), mt);
        $display("tick rst=%0b clr=%0b ld=%0b lv=%0d en=%0b up=%0b | c10=%0d c6=%0d c32=%0d | cas=%0d%0d",
                 reset, clear, load, lv, en, up_dn, c10, c6, c32, ct, cu);
    endtask

    task automatic set_ctl(input bit r, input bit c, input bit l, input int v, input bit e, input bit u);
        reset = r; clear = c; load = l; lv = 5'(v); en = e; up_dn = u;
    endtask

    initial begin
        m10 = 0; m6 = 0; m32 = 0; mu = 0; mt = 0;
        w10 = 0; w6 = 0; w32 = 0; wu = 0; wt = 0;
        c_rst = 1'b1; c_en = 1'b0;
        set_ctl(1, 0, 0, 0, 0, 1);
        tick(); tick();
        check("reset_c10", int'(c10), 0);
        check("reset_c6_init", int'(c6), 2);
        check("reset_wr6", int'(wr6), 0);

        // Mod-10 up run across the 9 -> 0 boundary
        c_rst = 1'b0;
        set_ctl(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) tick();
        check("t1_c10_end", int'(c10), 2);
        check("t1_wr10", int'(wr10), 1);

        // Down step from 0 on mod-6
        set_ctl(0, 0, 1, 0, 0, 1); tick();
        set_ctl(0, 0, 0, 0, 1, 0); tick();
        check("t2_c6_down_wrap", int'(c6), 5);
        check("t2_wr6", int'(wr6), 1);

        // Load clamp and in-range load
        set_ctl(0, 0, 1, 7, 1, 1); tick();
        check("t3_clamp", int'(c6), 5);
        check("t3_wr_clr", int'(wr6), 0);
        set_ctl(0, 0, 1, 3, 1, 1); tick();
        check("t3_load3", int'(c6), 3);

        // Priority: clear over load over en, reset over everything
        set_ctl(0, 0, 1, 4, 0, 1); tick();
        set_ctl(0, 1, 1, 4, 1, 1); tick();
        check("t4_clear_prio", int'(c6), 2);
        set_ctl(0, 0, 1, 4, 0, 1); tick();
        set_ctl(1, 1, 1, 4, 1, 1); tick();
        check("t4_reset_prio", int'(c6), 2);

        // Full binary wrap on mod-32, cascade running 60 steps alongside
        c_rst = 1'b1;
        set_ctl(1, 0, 0, 0, 0, 1); tick();
        c_rst = 1'b0; c_en = 1'b1;
        set_ctl(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 60; i++) begin
            tick();
            check("t5_bcd", int'(ct) * 10 + int'(cu), (i + 1) % 60);
            if (i == 39) check("t6_c32_end", int'(c32), 8);
        end
        check("t5_tens_zero", int'(ct), 0);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            set_ctl($urandom_range(99, 0) < 2, $urandom_range(99, 0) < 5, $urandom_range(99, 0) < 10,
                    int'($urandom_range(31, 0)), $urandom_range(99, 0) < 75, $urandom_range(1, 0) == 1);
            c_rst = ($urandom_range(99, 0) < 2);
            c_en  = ($urandom_range(99, 0) < 85);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
